// File: rtl/board_io_pkg.sv
// ----------------------------------------------------------------------------
// board_io_pkg
//   Shared definitions for the board I/O front end: debounce FSM state
//   encodings and default timing parameters.
// ----------------------------------------------------------------------------
package board_io_pkg;

    // Debounce FSM state encodings
    localparam logic [1:0] REL        = 2'd0;
    localparam logic [1:0] PRESS_WAIT = 2'd1;
    localparam logic [1:0] PRESSED    = 2'd2;
    localparam logic [1:0] REL_WAIT   = 2'd3;

    localparam int unsigned DEBOUNCE_DEFAULT = 1000000;
    localparam int unsigned SYNC_DEFAULT     = 2;

endpackage

// File: rtl/sync_chain.sv
// ----------------------------------------------------------------------------
// sync_chain
//   Multi-stage flip-flop synchroniser for asynchronous inputs.
//   Each bit passes through STAGES flops.
// Ports:
//   clk  in   1      system clock
//   rst  in   1      synchronous active-high reset, clears every stage
//   d    in   WIDTH  asynchronous input
//   q    out  WIDTH  synchronised output (last stage)
// ----------------------------------------------------------------------------
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // stage_q[0] is the metastability-catching flop, stage_q[STAGES-1] the output
    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/button_switch_conditioner.sv
// ----------------------------------------------------------------------------
// button_switch_conditioner
//   Conditions a bouncy pushbutton and a slide-switch bus for the sequence
//   detector. Both are synchronised; the button is debounced by a 4-state
//   FSM that issues one single-cycle press_pulse per accepted press, and the
//   synchronised switches are snapshotted on that pulse.
// Ports:
//   clk          in   1     system clock
//   rst          in   1     synchronous active-high reset
//   button_raw   in   1     asynchronous pushbutton, 1 = pressed
//   switch_raw   in   SW_W  asynchronous slide switches
//   press_pulse  out  1     one-cycle strobe per accepted press
//   switch_snap  out  SW_W  switch value captured with press_pulse
//   pressed      out  1     debounced button level
// ----------------------------------------------------------------------------
module button_switch_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_DEFAULT,
    parameter int unsigned SW_W            = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            button_raw,
    input  logic [SW_W-1:0] switch_raw,
    output logic            press_pulse,
    output logic [SW_W-1:0] switch_snap,
    output logic            pressed
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic            btn_s;
    logic [SW_W-1:0] sw_s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic [SW_W-1:0]  snap_q, snap_d;

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_raw),
        .q   (btn_s)
    );

    sync_chain #(
        .WIDTH  (SW_W),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (switch_raw),
        .q   (sw_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        snap_d  = snap_q;
        case (state_q)
            REL: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                // A bounce in the final count cycle still aborts the press
                if (!btn_s) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                    snap_d  = sw_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                // Returning high is release bounce: back to PRESSED, no new pulse
                if (btn_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REL;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            snap_q  <= snap_d;
        end
    end

    assign press_pulse = pulse_q;
    assign switch_snap = snap_q;
    assign pressed     = (state_q == PRESSED) || (state_q == REL_WAIT);

endmodule

// File: tb/tb_button_switch_conditioner.sv
module tb_button_switch_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned SW_W = 8;
    // Drive at negedge before E0; pulse observed at the negedge after E(SYNC+DEB)
    localparam int unsigned LAT  = 1 + SYNC + DEB;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            button_raw = 1'b0;
    logic [SW_W-1:0] switch_raw = '0;
    logic            press_pulse;
    logic [SW_W-1:0] switch_snap;
    logic            pressed;

    typedef struct {
        int unsigned     cyc;
        logic [SW_W-1:0] snap;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    button_switch_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC),
        .SW_W            (SW_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_raw  (button_raw),
        .switch_raw  (switch_raw),
        .press_pulse (press_pulse),
        .switch_snap (switch_snap),
        .pressed     (pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: count the edge, then monitor outputs at the falling edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (press_pulse) begin
            check("pulse_was_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_snap", 32'(switch_snap), 32'(e.snap));
            end
        end
        if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            check("pulse_missing_at", cyc, exp_q[0].cyc);
            e = exp_q.pop_front();
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press_expect(input logic [SW_W-1:0] sw);
        exp_t e;
        button_raw = 1'b1;
        e.cyc  = cyc + LAT;
        e.snap = sw;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        ticks(3);
        check("rst_pulse", 32'(press_pulse), 32'd0);
        check("rst_snap", 32'(switch_snap), 32'd0);
        check("rst_pressed", 32'(pressed), 32'd0);
        rst = 1'b0;
        switch_raw = 8'hA5;
        ticks(3);
        check("idle_pressed", 32'(pressed), 32'd0);

        // Clean press with snapshot A5
        press_expect(8'hA5);
        ticks(SYNC + DEB);
        check("t1_pressed_before", 32'(pressed), 32'd0);
        tick();
        check("t1_pressed_after", 32'(pressed), 32'd1);
        tick();
        check("t1_pulse_one_cycle", 32'(press_pulse), 32'd0);
        check("t1_snap", 32'(switch_snap), 32'hA5);

        // Switch moves while held must not show
        switch_raw = 8'h3C;
        ticks(10);
        check("t3_snap_held", 32'(switch_snap), 32'hA5);
        button_raw = 1'b0;
        ticks(10);
        check("t3_released", 32'(pressed), 32'd0);
        check("t3_snap_after_rel", 32'(switch_snap), 32'hA5);
        press_expect(8'h3C);
        ticks(10);
        check("t3_snap_new", 32'(switch_snap), 32'h3C);
        check("t3_queue_empty", exp_q.size(), 32'd0);
        button_raw = 1'b0;
        ticks(10);

        // Press bounce: 3 high, 1 low, then held
        button_raw = 1'b1;
        ticks(3);
        button_raw = 1'b0;
        tick();
        press_expect(8'h3C);
        ticks(12);
        check("t2_queue_empty", exp_q.size(), 32'd0);
        check("t2_pressed", 32'(pressed), 32'd1);
        button_raw = 1'b0;
        ticks(10);

        // Release bounce keeps pressed high, then exact release timing
        press_expect(8'h3C);
        ticks(10);
        button_raw = 1'b0;
        tick();
        check("t4_bounce_a", 32'(pressed), 32'd1);
        tick();
        check("t4_bounce_b", 32'(pressed), 32'd1);
        button_raw = 1'b1;
        tick();
        check("t4_bounce_c", 32'(pressed), 32'd1);
        ticks(8);
        check("t4_bounce_d", 32'(pressed), 32'd1);
        check("t4_queue_empty", exp_q.size(), 32'd0);
        button_raw = 1'b0;
        ticks(SYNC + DEB);
        check("t4_rel_before", 32'(pressed), 32'd1);
        tick();
        check("t4_rel_after", 32'(pressed), 32'd0);
        ticks(5);

        // Reset at E4 of a press drops it; button still held afterwards
        switch_raw = 8'h5A;
        ticks(3);
        button_raw = 1'b1;
        ticks(4);
        rst = 1'b1;
        tick();
        check("t5_rst_pulse", 32'(press_pulse), 32'd0);
        check("t5_rst_snap", 32'(switch_snap), 32'd0);
        check("t5_rst_pressed", 32'(pressed), 32'd0);
        rst = 1'b0;
        press_expect(8'h5A);
        ticks(12);
        check("t5_queue_empty", exp_q.size(), 32'd0);
        check("t5_snap", 32'(switch_snap), 32'h5A);
        button_raw = 1'b0;
        ticks(10);

        // Long hold yields a single pulse
        press_expect(8'h5A);
        ticks(1000);
        check("t6_pressed", 32'(pressed), 32'd1);
        check("t6_queue_empty", exp_q.size(), 32'd0);
        button_raw = 1'b0;
        ticks(10);
        check("t6_released", 32'(pressed), 32'd0);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
